// File: rtl/encode_pri_seq_pkg.sv
// Shared constants and helpers for the sequential priority encoder.
package encode_pri_seq_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/encode_pri_seq_pri_sel.sv
// Combinational wrap-around search: first set request starting at 'start',
// walking upward (REV=0) or downward (REV=1) modulo N.
module pri_sel #(
  parameter int N   = 8,
  parameter int W   = 3,
  parameter bit REV = 1'b0
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);
  always_comb begin
    int s;
    int j;
    idx   = '0;
    found = 1'b0;
    s     = int'(start);
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = REV ? ((s - k + N) % N) : ((s + k) % N);
      if (!found && req[j]) begin
        idx   = W'(j);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/encode_pri_seq.sv
// Event encoder: latches strobes into a pending set and hands out one
// encoded index per valid/ready transfer, fixed priority or round-robin.
module encode_pri_seq
  import encode_pri_seq_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = 3,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] x,
  output logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pend,
  output logic         overflow
);
  if (W != idx_w(N)) begin : g_bad_w
    $error("encode_pri_seq: W must equal clog2(N)");
  end

  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [W-1:0] ptr;
  logic [W-1:0] start;
  logic [W-1:0] sel;
  logic         found;
  logic         load;
  logic [N-1:0] gclr;
  logic [N-1:0] ev;
  logic [N-1:0] pend_nxt;
  logic         ovf_hit;

  // Fixed priority is a downward search from the top line; round-robin
  // searches upward from just past the last grant.
  assign start = (MODE == MODE_RR) ? ((ptr == LAST) ? '0 : ptr + 1'b1) : LAST;

  pri_sel #(
    .N  (N),
    .W  (W),
    .REV(MODE == MODE_FIXED)
  ) u_sel (
    .req  (pend),
    .start(start),
    .idx  (sel),
    .found(found)
  );

  assign load     = (~out_valid | out_ready) & found;
  assign gclr     = load ? (ONE << sel) : '0;
  assign ev       = en ? x : '0;
  // New events are OR-ed after the grant clear so a same-cycle re-event survives.
  assign pend_nxt = (pend & ~gclr) | ev;
  assign ovf_hit  = |(ev & pend & ~gclr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      ptr       <= LAST;
    end else if (clr) begin
      pend      <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      ptr       <= LAST;
    end else begin
      pend <= pend_nxt;
      if (ovf_hit) overflow <= 1'b1;
      if (load) begin
        y         <= sel;
        out_valid <= 1'b1;
        ptr       <= sel;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_encode_pri_seq.sv
// Directed bench: one fixed-priority and one round-robin instance on shared stimulus.
module tb_encode_pri_seq;
  logic       clk = 1'b0;
  logic       rst_n, clr, en, out_ready;
  logic [7:0] x;
  logic [2:0] y0, y1;
  logic       ov0, ov1, of0, of1;
  logic [7:0] pend0, pend1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  encode_pri_seq #(.N(8), .W(3), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .x(x), .y(y0),
    .out_valid(ov0), .out_ready(out_ready), .pend(pend0), .overflow(of0)
  );
  encode_pri_seq #(.N(8), .W(3), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .x(x), .y(y1),
    .out_valid(ov1), .out_ready(out_ready), .pend(pend1), .overflow(of1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; x = '0;
    step();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; en = 1'b0; out_ready = 1'b0; x = '0;
    step(); step();
    chk("rst_y0", y0, 0); chk("rst_ov0", ov0, 0); chk("rst_pend0", pend0, 0);
    chk("rst_of0", of0, 0); chk("rst_ov1", ov1, 0); chk("rst_pend1", pend1, 0);
    #3 rst_n = 1'b1;

    // 1: fixed priority, two events drain highest first
    en = 1'b1; out_ready = 1'b1; x = 8'h90;
    step(); x = '0;
    chk("t1_pend", pend0, 8'h90); chk("t1_ov_lat", ov0, 0);
    step();
    chk("t1_ov_a", ov0, 1); chk("t1_y_a", y0, 7); chk("t1_pend_a", pend0, 8'h10);
    step();
    chk("t1_ov_b", ov0, 1); chk("t1_y_b", y0, 4);
    step();
    chk("t1_ov_c", ov0, 0); chk("t1_y_hold", y0, 4); chk("t1_of", of0, 0);

    // 2: backpressure holds the output
    out_ready = 1'b0; x = 8'h05;
    step(); x = '0;
    chk("t2_pend", pend0, 8'h05);
    step();
    chk("t2_y", y0, 2); chk("t2_ov", ov0, 1); chk("t2_pend1", pend0, 8'h01);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_y", y0, 2); chk("t2_hold_ov", ov0, 1); chk("t2_hold_p", pend0, 8'h01);
    end
    out_ready = 1'b1;
    step();
    chk("t2_y0", y0, 0); chk("t2_ov_b", ov0, 1); chk("t2_pend0", pend0, 0);
    step();
    chk("t2_ov_c", ov0, 0);

    // 3: round-robin full sweep, then wrap from ptr=7
    do_clr();
    x = 8'hFF;
    step(); x = '0;
    chk("t3_pend", pend1, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3_y", y1, i); chk("t3_ov", ov1, 1);
    end
    step();
    chk("t3_ov_end", ov1, 0); chk("t3_pend_end", pend1, 0);
    x = 8'h03;
    step(); x = '0;
    step();
    chk("t3_wrap_a", y1, 0);
    step();
    chk("t3_wrap_b", y1, 1);
    step();

    // 4: set-wins on grant, then overflow on duplicate
    do_clr();
    out_ready = 1'b0; x = 8'h08;
    step();
    chk("t4_pend", pend0, 8'h08);
    step();
    chk("t4_setwins", pend0, 8'h08); chk("t4_y", y0, 3); chk("t4_of0", of0, 0);
    step(); x = '0;
    chk("t4_of1", of0, 1);
    step();
    chk("t4_of_sticky", of0, 1);
    do_clr();
    chk("t4_clr_pend", pend0, 0); chk("t4_clr_ov", ov0, 0);
    chk("t4_clr_of", of0, 0); chk("t4_clr_y", y0, 0);

    // 5: en=0 masks events
    en = 1'b0; out_ready = 1'b1; x = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_pend0", pend0, 0); chk("t5_ov0", ov0, 0);
      chk("t5_pend1", pend1, 0); chk("t5_ov1", ov1, 0);
    end

    // 6: asynchronous reset mid-transfer
    do_clr();
    en = 1'b1; out_ready = 1'b0; x = 8'h10;
    step(); x = 8'h30;
    step(); x = '0;
    chk("t6_pre_ov", ov1, 1); chk("t6_pre_pend", pend1, 8'h30); chk("t6_pre_of", of1, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_ov1", ov1, 0); chk("t6_pend1", pend1, 0); chk("t6_y1", y1, 0);
    chk("t6_ov0", ov0, 0); chk("t6_pend0", pend0, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("t6_no_spur", ov1, 0);
    x = 8'h81;
    step(); x = '0;
    step();
    chk("t6_rr_restart", y1, 0); chk("t6_fixed", y0, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
